// File: rtl/song_reader_if.sv
// Bundle of control, note-player and song-ROM signals around the song reader.
// master = surrounding system (control FSM, note player, ROM); slave = song_reader.
interface song_reader_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5
);
  logic                      play;
  logic                      reset_player;
  logic [1:0]                song;
  logic                      note_done;
  logic [IDX_W+1:0]          rom_addr;
  logic [NOTE_W+DUR_W-1:0]   rom_data;
  logic [NOTE_W-1:0]         note;
  logic [DUR_W-1:0]          duration;
  logic                      new_note;
  logic                      song_done;

  modport master (
    output play, reset_player, song, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );

  modport slave (
    input  play, reset_player, song, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Walks the selected song in the synchronous ROM, hands each note to the note
// player with a new_note pulse and reports the end of the song with song_done.
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5
) (
  input  logic           clk,
  input  logic           reset,
  song_reader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [NOTE_W-1:0]   r_note;
  logic [DUR_W-1:0]    r_duration;
  logic                r_new_note;
  logic                r_song_done;

  logic [NOTE_W-1:0]   w_rom_note;
  logic [DUR_W-1:0]    w_rom_dur;
  logic                w_last_idx;

  assign w_rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur  = bus.rom_data[DUR_W-1:0];
  assign w_last_idx = &r_idx;

  assign bus.rom_addr  = {bus.song, r_idx};
  assign bus.note      = r_note;
  assign bus.duration  = r_duration;
  assign bus.new_note  = r_new_note;
  assign bus.song_done = r_song_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_note      <= '0;
      r_duration  <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
      if (bus.reset_player) begin
        r_state    <= S_IDLE;
        r_idx      <= '0;
        r_note     <= '0;
        r_duration <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.play) r_state <= S_FETCH;
          end
          // ROM samples the address here; its word is valid in LATCH.
          S_FETCH: r_state <= S_LATCH;
          S_LATCH: begin
            if (w_rom_dur == '0) begin
              r_state <= S_DONE;
            end else begin
              r_note     <= w_rom_note;
              r_duration <= w_rom_dur;
              r_new_note <= 1'b1;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.note_done) begin
              if (w_last_idx) begin
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= bus.play ? S_FETCH : S_IDLE;
              end
            end
          end
          S_DONE: begin
            r_song_done <= 1'b1;
            r_idx       <= '0;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Randomized bench for song_reader: ROM model, event-level reference derived
// from ROM contents, latency and pulse checks through one check task.
module tb_song_reader;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int IDX_W  = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [11:0] rom [0:127];

  song_reader_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) bus ();

  song_reader #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // synchronous ROM: word valid one cycle after the address
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rand_word();
    logic [5:0] n;
    logic [5:0] d;
    n = 6'($urandom_range(0, 63));
    d = 6'($urandom_range(1, 63));
    return {n, d};
  endfunction

  task automatic fill_random_songs();
    logic [11:0] w;
    int p;
    p = $urandom_range(1, 31);
    for (int i = 0; i < 32; i++) begin
      w = rand_word();
      if (i == p) w[5:0] = 6'd0;
      rom[64 + i] = w;
      w = rand_word();
      if ($urandom_range(0, 3) == 0) w[5:0] = 6'd0;
      rom[96 + i] = w;
    end
  endtask

  task automatic select_song(input logic [1:0] s);
    bus.song         = s;
    bus.play         = 1'b0;
    bus.note_done    = 1'b0;
    bus.reset_player = 1'b1;
    @(negedge clk);
    bus.reset_player = 1'b0;
  endtask

  // Counts falling edges until new_note (kind 1) or song_done (kind 2).
  // note_done is raised on falling edge nd_set and dropped on every other one.
  task automatic wait_evt(input int nd_set, output int n, output int kind);
    n    = 0;
    kind = 0;
    while (kind == 0 && n < 40) begin
      @(negedge clk);
      n++;
      bus.note_done = (n == nd_set);
      check("exclusive", 32'(bus.new_note & bus.song_done), 0);
      if (bus.new_note === 1'b1) kind = 1;
      else if (bus.song_done === 1'b1) kind = 2;
    end
    check("evt_seen", 32'(kind != 0), 1);
  endtask

  task automatic expect_evt(input string tag, input int nd_set, input int exp_kind, input int exp_lat);
    int n;
    int kind;
    wait_evt(nd_set, n, kind);
    check({tag, "_kind"}, kind, exp_kind);
    check({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic play_song(input logic [1:0] s, input bit allow_pause, input bit keep_play, input int fixed_d);
    logic [11:0] exp_q[$];
    logic [6:0]  a;
    int          d;
    int          k;
    bit          pause;
    for (int i = 0; i < 32; i++) begin
      a = {s, 5'(i)};
      if (rom[a][5:0] == 6'd0) break;
      exp_q.push_back(rom[a]);
    end
    select_song(s);
    bus.play = 1'b1;
    expect_evt("start", 0, exp_q.size() > 0 ? 1 : 2, exp_q.size() > 0 ? 3 : 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      check("note", 32'(bus.note), 32'(exp_q[i][11:6]));
      check("dur", 32'(bus.duration), 32'(exp_q[i][5:0]));
      check("addr", 32'(bus.rom_addr), 32'({s, 5'(i)}));
      d = (fixed_d > 0) ? fixed_d : $urandom_range(1, 3);
      repeat (d) begin
        @(negedge clk);
        check("pulse_low", 32'(bus.new_note), 0);
      end
      pause = allow_pause && (i < 31) && ($urandom_range(0, 2) == 0);
      bus.note_done = 1'b1;
      if (pause) begin
        bus.play = 1'b0;
        @(negedge clk);
        bus.note_done = 1'b0;
        k = $urandom_range(2, 5);
        repeat (k) begin
          check("pause_quiet", 32'(bus.new_note | bus.song_done), 0);
          check("pause_addr", 32'(bus.rom_addr), 32'({s, 5'(i + 1)}));
          @(negedge clk);
        end
        bus.play = 1'b1;
      end
      if (i + 1 < exp_q.size()) expect_evt(pause ? "resume" : "next", 0, 1, 3);
      else if (i == 31)         expect_evt("end_full", 0, 2, 2);
      else                      expect_evt("end_mark", 0, 2, 4);
    end
    check("end_addr", 32'(bus.rom_addr), 32'({s, 5'd0}));
    if (keep_play) begin
      expect_evt("replay", 0, exp_q.size() > 0 ? 1 : 2, exp_q.size() > 0 ? 3 : 4);
      if (exp_q.size() > 0) check("replay_note", 32'(bus.note), 32'(exp_q[0][11:6]));
    end else begin
      bus.play = 1'b0;
      @(negedge clk);
      check("sd_single", 32'(bus.song_done), 0);
      repeat (3) begin
        @(negedge clk);
        check("idle_quiet", 32'(bus.new_note), 0);
      end
    end
    $display("song %0d: %0d notes played", s, exp_q.size());
  endtask

  task automatic rp_test(input int k);
    select_song(2'd1);
    bus.play = 1'b1;
    repeat (k) @(negedge clk);
    bus.reset_player = 1'b1;
    @(negedge clk);
    bus.reset_player = 1'b0;
    bus.play         = 1'b0;
    check("rp_note", 32'(bus.note), 0);
    check("rp_dur", 32'(bus.duration), 0);
    check("rp_addr", 32'(bus.rom_addr), 32'({2'd1, 5'd0}));
    repeat (4) begin
      check("rp_quiet", 32'(bus.new_note | bus.song_done), 0);
      @(negedge clk);
    end
    $display("reset_player after %0d cycles of play", k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    bus.play         = 1'b0;
    bus.reset_player = 1'b0;
    bus.song         = 2'd0;
    bus.note_done    = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = rand_word();
    rom[0] = {6'd12, 6'd4};
    rom[1] = {6'd15, 6'd2};
    rom[2] = {6'd0,  6'd0};
    fill_random_songs();

    @(negedge clk);
    check("rst_note", 32'(bus.note), 0);
    check("rst_dur", 32'(bus.duration), 0);
    check("rst_new_note", 32'(bus.new_note), 0);
    check("rst_song_done", 32'(bus.song_done), 0);
    check("rst_addr", 32'(bus.rom_addr), 0);
    @(negedge clk);
    reset = 1'b1;

    play_song(2'd0, 1'b0, 1'b0, 2);
    play_song(2'd1, 1'b0, 1'b1, 0);

    rp_test(1);
    rp_test(2);
    rp_test(4);

    // reset_player on the same edge LATCH would enter DONE
    rom[96] = {6'd9, 6'd0};
    select_song(2'd3);
    bus.play = 1'b1;
    repeat (2) @(negedge clk);
    bus.reset_player = 1'b1;
    @(negedge clk);
    bus.reset_player = 1'b0;
    bus.play         = 1'b0;
    repeat (4) begin
      check("rp_done_sd", 32'(bus.song_done), 0);
      @(negedge clk);
    end
    $display("reset_player at DONE entry");

    // async reset between clock edges while waiting on note 1
    select_song(2'd0);
    bus.play = 1'b1;
    expect_evt("ar_n0", 0, 1, 3);
    @(negedge clk);
    bus.note_done = 1'b1;
    expect_evt("ar_n1", 0, 1, 3);
    check("ar_n1_note", 32'(bus.note), 15);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("ar_note", 32'(bus.note), 0);
    check("ar_dur", 32'(bus.duration), 0);
    check("ar_new_note", 32'(bus.new_note), 0);
    check("ar_addr", 32'(bus.rom_addr), 0);
    bus.play = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    $display("async reset mid-note");

    // note_done in IDLE and FETCH must be dropped
    bus.play = 1'b1;
    expect_evt("nd_start", 0, 1, 3);
    bus.play      = 1'b0;
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    check("nd_pause_addr", 32'(bus.rom_addr), 1);
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    check("nd_idle_addr", 32'(bus.rom_addr), 1);
    @(negedge clk);
    check("nd_idle_addr2", 32'(bus.rom_addr), 1);
    bus.play = 1'b1;
    expect_evt("nd_fetch", 1, 1, 3);
    check("nd_fetch_note", 32'(bus.note), 15);
    check("nd_fetch_addr", 32'(bus.rom_addr), 1);
    $display("note_done dropped in IDLE and FETCH");

    for (int iter = 0; iter < 4; iter++) begin
      select_song(2'd0);
      fill_random_songs();
      play_song(2'd2, 1'b1, 1'b0, 0);
      play_song(2'd3, 1'b1, 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
